// File: rtl/game_ctrl.sv
// Cursor / fire / win-lose controller for the battleship board.
// Define GAME_CTRL_AUTO_REPEAT_EN to enable auto-repeat of held direction buttons.
module game_ctrl #(
  parameter int SETTLE_CYC = 2,
  parameter int RPT_DELAY  = 25_000_000,
  parameter int RPT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic [4:0] turns_left,
  input  logic [4:0] sunk_flags,
  output logic [3:0] sprite_row,
  output logic [3:0] sprite_col,
  output logic       fire,
  output logic       clr_game,
  output logic [2:0] state,
  output logic [6:0] shots
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_LOSE  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       fire_q, fire_d;
  logic       clr_q, clr_d;
  logic [6:0] shots_q, shots_d;

  // Button vector order: {up, down, left, right, centre}
  logic [4:0] btn_now;
  logic [4:0] btn_prev_q;
  logic [4:0] held_q, held_d;
  logic [4:0] btn_edge;

  assign btn_now = {btn_u, btn_d, btn_l, btn_r, btn_c};

  // held_q marks buttons already down at reset; they stay masked until released.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_edge
      assign btn_edge[gi] = btn_now[gi] & ~btn_prev_q[gi] & ~held_q[gi];
      assign held_d[gi]   = held_q[gi] & btn_now[gi];
    end
  endgenerate

  logic [3:0] row_inc, row_dec, col_inc, col_dec;
  assign row_inc = (row_q == 4'd9) ? 4'd0 : row_q + 4'd1;
  assign row_dec = (row_q == 4'd0) ? 4'd9 : row_q - 4'd1;
  assign col_inc = (col_q == 4'd9) ? 4'd0 : col_q + 4'd1;
  assign col_dec = (col_q == 4'd0) ? 4'd9 : col_q - 4'd1;

  logic rpt_move;

`ifdef GAME_CTRL_AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_target, rpt_cnt_inc;
  logic             rpt_seen_q, rpt_seen_d;
  logic [3:0]       dir_now, dir_prev;
  logic             dir_single, rpt_hold;

  assign dir_now    = btn_now[4:1];
  assign dir_prev   = btn_prev_q[4:1];
  assign dir_single = (dir_now != 4'd0) && ((dir_now & (dir_now - 4'd1)) == 4'd0);
  // Any change of the direction vector (release, new press) or leaving PLAY restarts the count.
  assign rpt_hold   = (state_q == S_PLAY) && !btn_edge[0] && (dir_now == dir_prev) && dir_single;
  assign rpt_cnt_inc = rpt_cnt_q + RPT_W'(1);

  always_comb begin
    rpt_cnt_d  = '0;
    rpt_seen_d = 1'b0;
    rpt_move   = 1'b0;
    rpt_target = rpt_seen_q ? RPT_W'(RPT_PERIOD) : RPT_W'(RPT_DELAY);
    if (rpt_hold) begin
      if (rpt_cnt_inc == rpt_target) begin
        rpt_move   = 1'b1;
        rpt_seen_d = 1'b1;
        rpt_cnt_d  = '0;
      end else begin
        rpt_cnt_d  = rpt_cnt_inc;
        rpt_seen_d = rpt_seen_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q  <= '0;
      rpt_seen_q <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      rpt_seen_q <= rpt_seen_d;
    end
  end
`else
  assign rpt_move = 1'b0;
`endif

  // Fresh edges win over a repeat; a repeat reuses the single held direction.
  logic [3:0] move_req;
  always_comb begin
    move_req = 4'd0;
    if (|btn_edge[4:1]) begin
      move_req = btn_edge[4:1];
    end else if (rpt_move) begin
      move_req = btn_now[4:1];
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    wait_cnt_d = wait_cnt_q;
    fire_d     = 1'b0;
    clr_d      = 1'b0;
    shots_d    = shots_q;
    case (state_q)
      S_IDLE: begin
        if (btn_edge[0]) begin
          state_d = S_PLAY;
          row_d   = 4'd0;
          col_d   = 4'd0;
          shots_d = 7'd0;
          clr_d   = 1'b1;
        end
      end
      S_PLAY: begin
        if (btn_edge[0]) begin
          fire_d     = 1'b1;
          shots_d    = (shots_q == 7'd127) ? shots_q : shots_q + 7'd1;
          wait_cnt_d = 4'd0;
          state_d    = S_WAIT;
        end else if (move_req[3]) begin
          row_d = row_dec;
        end else if (move_req[2]) begin
          row_d = row_inc;
        end else if (move_req[1]) begin
          col_d = col_dec;
        end else if (move_req[0]) begin
          col_d = col_inc;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'(SETTLE_CYC - 1)) begin
          state_d = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (sunk_flags == 5'b11111) begin
          state_d = S_WIN;
        end else if (turns_left == 5'd0) begin
          state_d = S_LOSE;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_WIN, S_LOSE: begin
        if (btn_edge[0]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= 4'd0;
      col_q      <= 4'd0;
      wait_cnt_q <= 4'd0;
      fire_q     <= 1'b0;
      clr_q      <= 1'b0;
      shots_q    <= 7'd0;
      btn_prev_q <= 5'd0;
      held_q     <= btn_now;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wait_cnt_q <= wait_cnt_d;
      fire_q     <= fire_d;
      clr_q      <= clr_d;
      shots_q    <= shots_d;
      btn_prev_q <= btn_now;
      held_q     <= held_d;
    end
  end

  assign sprite_row = row_q;
  assign sprite_col = col_q;
  assign fire       = fire_q;
  assign clr_game   = clr_q;
  assign state      = state_q;
  assign shots      = shots_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2, sets the cycles spent in WAIT after a fire pulse; legal range 1..15.
REQ-002 Parameter RPT_DELAY, default 25_000_000, sets the cycles a direction button must be held before the first auto-repeat.
REQ-003 Parameter RPT_PERIOD, default 5_000_000, sets the cycles between later auto-repeats.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Ports btn_u, btn_d, btn_l, btn_r, btn_c, input, 1 each: buttons, already debounced, level-sensitive.
REQ-007 Port turns_left, input, 5: remaining-miss count from the game-state block.
REQ-008 Port sunk_flags, input, 5: one bit per ship, 1 = ship sunk.
REQ-009 Port sprite_row, output, 4: cursor row, 0..9.
REQ-010 Port sprite_col, output, 4: cursor column, 0..9.
REQ-011 Port fire, output, 1: one-cycle bomb strobe to the game-state block.
REQ-012 Port clr_game, output, 1: one-cycle request to clear the game-state block.
REQ-013 Port state, output, 3: encoding IDLE=0, PLAY=1, WAIT=2, CHECK=3, WIN=4, LOSE=5.
REQ-014 Port shots, output, 7: count of fire pulses, saturating at 127.

Function
REQ-015 Button edges are detected with one register stage per button; an edge is "current high, previous low", and the registered action is visible the next cycle.
REQ-016 IDLE, on btn_c edge: go to PLAY, set the cursor to (0,0), clear shots, and pulse clr_game for 1 cycle.
REQ-017 PLAY, on a direction edge: move the cursor by 1 with wrap-around (row 9 + down -> 0, row 0 + up -> 9, and the same for columns).
REQ-018 PLAY, on simultaneous direction edges: apply only one move per cycle, with priority up > down > left > right.
REQ-019 PLAY, on btn_c edge: assert fire the next cycle for exactly 1 cycle, increment shots, and enter WAIT; any direction edge in the same cycle is discarded.
REQ-020 WAIT lasts exactly SETTLE_CYC cycles, then goes to CHECK; all buttons are ignored in WAIT and the cursor is frozen.
REQ-021 CHECK lasts 1 cycle:
- sunk_flags == 5'b11111 -> WIN;
- else turns_left == 0 -> LOSE;
- else -> PLAY.
REQ-022 When win and loss conditions hold together, WIN takes priority.
REQ-023 WIN and LOSE hold the cursor and shots; a btn_c edge goes to IDLE, and direction buttons are ignored.
REQ-024 The fire and clr_game pulses are never asserted in the same cycle, and never for 2 consecutive cycles.
REQ-025 Once shots reaches 127 it stays at 127.
REQ-026 The cursor outputs never take values 10..15.

Reset
REQ-027 While reset is high at a clock edge, the block shall be set to:
- state = IDLE;
- sprite_row = sprite_col = 0;
- fire = 0, clr_game = 0, shots = 0;
- edge registers and repeat counters cleared.
REQ-028 Reset asserted in any state, including mid-WAIT, takes effect on the next edge and suppresses any pending fire pulse.
REQ-029 After reset, a button already held high produces no edge until it is released and pressed again.

Configuration
REQ-030 With macro GAME_CTRL_AUTO_REPEAT_EN defined, in PLAY a single held direction button generates an extra move after RPT_DELAY cycles, then one every RPT_PERIOD cycles.
REQ-031 The auto-repeat counter restarts on release, on a change of button, or on leaving PLAY.
REQ-032 Without GAME_CTRL_AUTO_REPEAT_EN, only edges move the cursor, and no repeat counters are synthesized.

Verification
REQ-033 Scenario, reset and start: reset, then btn_c edge -> state=1, cursor (0,0), and clr_game high for exactly 1 cycle.
REQ-034 Scenario, wrap and priority:
- in PLAY at (0,0), btn_u edge -> row=9;
- then btn_l edge -> col=9;
- btn_u and btn_r edges together -> only the row changes.
REQ-035 Scenario, fire sequence: in PLAY, btn_c edge with turns_left=3 and sunk_flags=0 ->
- fire high 1 cycle;
- shots=1;
- state 2 for 2 cycles, then 3, then 1.
REQ-036 Scenario, loss: fire with turns_left=0 at CHECK -> state=5; a later btn_c edge -> state=0.
REQ-037 Scenario, win priority: fire with sunk_flags=5'b11111 and turns_left=0 at CHECK -> state=4.
REQ-038 Scenario, reset mid-WAIT: assert reset during WAIT -> state=0, fire=0, shots=0 on the next cycle.
REQ-039 Scenario, auto-repeat (with macro, RPT_DELAY=4, RPT_PERIOD=2): hold btn_d for 10 cycles from row 0 -> rows 1, 2, 3, 4 at cycles 1, 5, 7, 9.
